// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_MEM = 2'd1,
        HALT     = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // next count: increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC owner: arbitrates halt, redirect, load-use and imem wait each cycle
// and drives the IF/ID and ID/EX pipeline controls.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    input  logic             load_use_hazard,
    input  logic             halt_req,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc_plus4,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             misalign_err,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_valid_q, pend_valid_d;
    logic        misalign_q, misalign_d;
    logic        if_id_en_s, if_id_flush_s, id_ex_flush_s, stall_inc_s;

    // per-cycle arbitration: halt > redirect > load-use > imem wait > sequential
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        misalign_d    = misalign_q;
        if_id_en_s    = 1'b0;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;
        stall_inc_s   = 1'b0;
        case (state_q)
            FETCH, WAIT_MEM: begin
                if (halt_req) begin
                    if_id_en_s    = 1'b1;
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    pend_valid_d  = 1'b0;
                    state_d       = HALT;
                end else if (redirect_valid) begin
                    if_id_en_s    = 1'b1;
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    if (is_misaligned(redirect_target)) begin
                        misalign_d   = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = HALT;
                    end else if (imem_ready || (state_q == FETCH)) begin
                        pc_d         = redirect_target;
                        pend_valid_d = 1'b0;
                        state_d      = FETCH;
                    end else begin
                        // fetch still outstanding: park the target until it returns
                        pend_target_d = redirect_target;
                        pend_valid_d  = 1'b1;
                        stall_inc_s   = 1'b1;
                    end
                end else if (load_use_hazard) begin
                    id_ex_flush_s = 1'b1;
                    stall_inc_s   = 1'b1;
                end else if (!imem_ready) begin
                    if_id_en_s    = 1'b1;
                    if_id_flush_s = 1'b1;
                    stall_inc_s   = 1'b1;
                    state_d       = WAIT_MEM;
                end else begin
                    if_id_en_s   = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = FETCH;
                    if (pend_valid_q) begin
                        if_id_flush_s = 1'b1;
                        pc_d          = pend_target_q;
                    end else begin
                        pc_d = pc_q + PC_INC;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // state, PC, pending redirect and sticky error registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0000_0000;
            pend_valid_q  <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .inc_i   (stall_inc_s),
        .count_o (stall_cycles)
    );

    // pipeline controls are forced quiet while reset is held
    assign imem_req     = reset_n & (state_q != HALT);
    assign if_id_en     = reset_n & if_id_en_s;
    assign if_id_flush  = reset_n & if_id_flush_s;
    assign id_ex_flush  = reset_n & id_ex_flush_s;
    assign imem_addr    = pc_q;
    assign pc_plus4     = pc_q + PC_INC;
    assign misalign_err = misalign_q;
    assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_pc_sequencer;

    localparam int TB_CNT_W = 4;
    localparam int STALL_MAX = 15;

    logic        clk;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        load_use_hazard;
    logic        halt_req;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_plus4;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        misalign_err;
    logic        halted;
    logic [TB_CNT_W-1:0] stall_cycles;

    logic        rst2_n;
    logic        rv2;
    logic [31:0] rt2;
    logic        ready2;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] p4_2;
    logic        en2;
    logic        iff2;
    logic        idf2;
    logic        mis2;
    logic        halted2;
    logic [15:0] stall2;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    logic [31:0] m_pc;
    bit          m_wait;
    bit          m_halt;
    bit          m_pend;
    logic [31:0] m_tgt;
    bit          m_mis;
    int          m_stall;

    // last sampled DUT outputs
    logic [31:0] s_addr;
    logic        s_req, s_en, s_iff, s_idf, s_mis, s_halted;
    logic [TB_CNT_W-1:0] s_stall;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(TB_CNT_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .load_use_hazard (load_use_hazard),
        .halt_req        (halt_req),
        .imem_ready      (imem_ready),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .pc_plus4        (pc_plus4),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .misalign_err    (misalign_err),
        .halted          (halted),
        .stall_cycles    (stall_cycles)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut2 (
        .clk             (clk),
        .reset_n         (rst2_n),
        .redirect_valid  (rv2),
        .redirect_target (rt2),
        .load_use_hazard (1'b0),
        .halt_req        (1'b0),
        .imem_ready      (ready2),
        .imem_req        (req2),
        .imem_addr       (addr2),
        .pc_plus4        (p4_2),
        .if_id_en        (en2),
        .if_id_flush     (iff2),
        .id_ex_flush     (idf2),
        .misalign_err    (mis2),
        .halted          (halted2),
        .stall_cycles    (stall2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_0000; m_wait = 0; m_halt = 0; m_pend = 0;
        m_tgt = 32'h0000_0000; m_mis = 0; m_stall = 0;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= STALL_MAX) ? STALL_MAX : v + 1;
    endfunction

    // called at posedge+1: drive, check at negedge against model, advance model, return at next posedge+1
    task automatic do_cycle(input logic rv, input logic [31:0] rt, input logic lu,
                            input logic hr, input logic rdy);
        logic e_en, e_iff, e_idf;
        redirect_valid = rv; redirect_target = rt; load_use_hazard = lu;
        halt_req = hr; imem_ready = rdy;
        @(negedge clk);
        s_addr = imem_addr; s_req = imem_req; s_en = if_id_en; s_iff = if_id_flush;
        s_idf = id_ex_flush; s_mis = misalign_err; s_halted = halted; s_stall = stall_cycles;
        if (m_halt)      begin e_en = 1'b0; e_iff = 1'b0;   e_idf = 1'b0; end
        else if (hr)     begin e_en = 1'b1; e_iff = 1'b1;   e_idf = 1'b1; end
        else if (rv)     begin e_en = 1'b1; e_iff = 1'b1;   e_idf = 1'b1; end
        else if (lu)     begin e_en = 1'b0; e_iff = 1'b0;   e_idf = 1'b1; end
        else if (!rdy)   begin e_en = 1'b1; e_iff = 1'b1;   e_idf = 1'b0; end
        else             begin e_en = 1'b1; e_iff = m_pend; e_idf = 1'b0; end
        chk("imem_addr", s_addr, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("imem_req", {31'd0, s_req}, {31'd0, !m_halt});
        chk("if_id_en", {31'd0, s_en}, {31'd0, e_en});
        chk("if_id_flush", {31'd0, s_iff}, {31'd0, e_iff});
        chk("id_ex_flush", {31'd0, s_idf}, {31'd0, e_idf});
        chk("misalign_err", {31'd0, s_mis}, {31'd0, m_mis});
        chk("halted", {31'd0, s_halted}, {31'd0, m_halt});
        chk("stall_cycles", {28'd0, s_stall}, m_stall);
        if (m_halt) begin
        end else if (hr) begin
            m_halt = 1; m_pend = 0;
        end else if (rv) begin
            if (rt[1:0] != 2'b00) begin
                m_mis = 1; m_halt = 1; m_pend = 0;
            end else if (rdy || !m_wait) begin
                m_pc = rt; m_wait = 0; m_pend = 0;
            end else begin
                m_pend = 1; m_tgt = rt; m_stall = sat_inc(m_stall);
            end
        end else if (lu) begin
            m_stall = sat_inc(m_stall);
        end else if (!rdy) begin
            m_wait = 1; m_stall = sat_inc(m_stall);
        end else begin
            m_pc = m_pend ? m_tgt : m_pc + 32'd4;
            m_pend = 0; m_wait = 0;
        end
        @(posedge clk); #1;
    endtask

    // called at posedge+1: asynchronous reset mid-cycle, checked before any clock edge
    task automatic reset_main();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_en", {31'd0, if_id_en}, 32'd0);
        chk("rst_iff", {31'd0, if_id_flush}, 32'd0);
        chk("rst_idf", {31'd0, id_ex_flush}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_mis", {31'd0, misalign_err}, 32'd0);
        chk("rst_stall", {28'd0, stall_cycles}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rt;
        reset_n = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        load_use_hazard = 1'b0; halt_req = 1'b0; imem_ready = 1'b0;
        rst2_n = 1'b0; rv2 = 1'b0; rt2 = 32'h0; ready2 = 1'b0;
        model_reset();

        // wrap-around and reset-during-wait on the high RESET_PC instance
        repeat (2) @(posedge clk);
        #1 rst2_n = 1'b1; ready2 = 1'b1;
        @(negedge clk);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        chk("wrap_p4", p4_2, 32'h0000_0000);
        @(posedge clk); #1 ready2 = 1'b0;
        @(negedge clk);
        chk("wrap_addr1", addr2, 32'h0000_0000);
        @(posedge clk); #1 rv2 = 1'b1; rt2 = 32'h0000_0100;
        @(posedge clk); #1 rv2 = 1'b0;
        @(negedge clk);
        chk("wait_hold", addr2, 32'h0000_0000);
        @(posedge clk); #3 rst2_n = 1'b0;
        #1;
        chk("async_addr", addr2, 32'hFFFF_FFFC);
        chk("async_req", {31'd0, req2}, 32'd0);
        @(posedge clk); #1 rst2_n = 1'b1; ready2 = 1'b1;
        @(negedge clk);
        chk("post_rst_addr", addr2, 32'hFFFF_FFFC);
        chk("post_rst_iff", {31'd0, iff2}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pend_dropped", addr2, 32'h0000_0000);

        // directed main-instance scenarios
        @(posedge clk); #1;
        reset_main();
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("seq0", s_addr, 32'h0); chk("seq0_en", {31'd0, s_en}, 32'd1);
        chk("seq0_iff", {31'd0, s_iff}, 32'd0);
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("seq1", s_addr, 32'h4);
        do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("lu_addr", s_addr, 32'h8); chk("lu_en", {31'd0, s_en}, 32'd0);
        chk("lu_idf", {31'd0, s_idf}, 32'd1);
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("lu_hold", s_addr, 32'h8); chk("lu_stall", {28'd0, s_stall}, 32'd1);
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("lu_after", s_addr, 32'hC);
        do_cycle(1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        chk("rdlu_addr", s_addr, 32'h10); chk("rdlu_iff", {31'd0, s_iff}, 32'd1);
        chk("rdlu_idf", {31'd0, s_idf}, 32'd1);
        do_cycle(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
        chk("rd_addr", s_addr, 32'h40); chk("rd_stall", {28'd0, s_stall}, 32'd1);
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("wait_addr", s_addr, 32'h20); chk("wait_iff", {31'd0, s_iff}, 32'd1);
        chk("wait_en", {31'd0, s_en}, 32'd1);
        do_cycle(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("discard_iff", {31'd0, s_iff}, 32'd1); chk("discard_addr", s_addr, 32'h20);
        do_cycle(1'b1, 32'h42, 1'b0, 1'b0, 1'b1);
        chk("pend_pc", s_addr, 32'h80); chk("pend_stall", {28'd0, s_stall}, 32'd4);
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("mis_err", {31'd0, s_mis}, 32'd1); chk("mis_halted", {31'd0, s_halted}, 32'd1);
        chk("mis_req", {31'd0, s_req}, 32'd0); chk("mis_addr", s_addr, 32'h80);
        reset_main();

        // randomized segments, each opened by an asynchronous mid-cycle reset
        for (int seg = 0; seg < 40; seg++) begin
            for (int c = 0; c < 25; c++) begin
                rt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                if ($urandom_range(0, 9) == 0) rt[1:0] = 2'($urandom_range(1, 3));
                do_cycle($urandom_range(0, 4) == 0, rt, $urandom_range(0, 5) == 0,
                         $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);
            end
            reset_main();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
